// File: rtl/systolic_feeder.sv
// Head-of-chain sequencer: joins coefficient and data streams into one beat per
// cycle, tags frame starts, and flushes the systolic chain with zero bubbles.
module systolic_feeder #(
   parameter int WIDTH        = 32,
   parameter int N_CELLS      = 4,
   parameter int FLUSH_CYCLES = N_CELLS,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] c_in_data,
   input  logic             c_in_valid,
   output logic             c_in_ready,
   input  logic [WIDTH-1:0] x_in_data,
   input  logic             x_in_valid,
   input  logic             x_in_last,
   output logic             x_in_ready,
   output logic [WIDTH-1:0] c_out,
   output logic [WIDTH-1:0] x_out,
   output logic             s_out,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_beats
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt;
   logic [FC_W-1:0]  flush_cnt;
   logic             accept_en;
   logic             beat;
   logic             flush_end;

   // Holding readys low while reset is asserted keeps anything from being consumed.
   assign accept_en  = (state_q != FLUSH) & rst;
   assign c_in_ready = x_in_valid & accept_en;
   assign x_in_ready = c_in_valid & accept_en;
   assign beat       = c_in_valid & x_in_valid & accept_en;
   assign busy       = (state_q != IDLE);
   assign flush_end  = (state_q == FLUSH) && (flush_cnt == FC_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (beat) state_d = x_in_last ? FLUSH : STREAM;
         STREAM:  if (beat && x_in_last) state_d = FLUSH;
         FLUSH:   if (flush_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: no beat means a zero bubble, so the array never stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_out       <= '0;
         x_out       <= '0;
         s_out       <= 1'b0;
         frame_done  <= 1'b0;
         frame_beats <= '0;
         beat_cnt    <= '0;
         flush_cnt   <= '0;
      end else begin
         c_out      <= beat ? c_in_data : '0;
         x_out      <= beat ? x_in_data : '0;
         s_out      <= beat && (state_q == IDLE);
         frame_done <= 1'b0;
         if (beat) begin
            if (state_q == IDLE)     beat_cnt <= CNT_W'(1);
            else if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
            if (x_in_last)           flush_cnt <= FC_W'(FLUSH_CYCLES);
         end
         if (state_q == FLUSH) begin
            flush_cnt <= flush_cnt - FC_W'(1);
            if (flush_end) begin
               frame_done  <= 1'b1;
               frame_beats <= beat_cnt;
               beat_cnt    <= '0;
            end
         end
      end
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Head-of-array sequencer driving the c/x/s inputs of the first internal cell of the systolic chain. Joins a coefficient stream and a data stream into one beat per cycle and marks the first beat of each frame with s=1. After a frame, flushes the chain with zero bubbles so results drain before the next frame. Reports frame completion and beat count to the controller.

Parameters:
WIDTH, 32, data width of c and x paths (matches cell datapath)
N_CELLS, 4, number of internal cells in the chain
FLUSH_CYCLES, N_CELLS, zero-bubble cycles emitted after the last beat of a frame (must be >= 1)
CNT_W, 16, width of the frame beat counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
c_in_data  in  WIDTH  coefficient word
c_in_valid  in  1  coefficient valid
c_in_ready  out  1  coefficient accepted when valid & ready
x_in_data  in  WIDTH  data word
x_in_valid  in  1  data valid
x_in_last  in  1  marks final data beat of a frame
x_in_ready  out  1  data accepted when valid & ready
c_out  out  WIDTH  to cell c_in
x_out  out  WIDTH  to cell x_in
s_out  out  1  to cell s_in; frame-start marker
busy  out  1  high in STREAM or FLUSH
frame_done  out  1  one-cycle pulse at end of flush
frame_beats  out  CNT_W  beats in the most recent completed frame

Behaviour:
- Reset (rst=0, async): state=IDLE; c_out, x_out, s_out, frame_done, frame_beats, internal beat counter, flush counter all 0.
- Beat = edge where c_in_valid & x_in_valid & accept_en. accept_en = (state != FLUSH).
- Join: c_in_ready = x_in_valid & accept_en; x_in_ready = c_in_valid & accept_en. No word is consumed from either stream alone. Ready is combinational from the partner valid and state only, never from its own valid.
- Outputs are registered, latency 1: beat at edge k -> c_out/x_out hold that pair during cycle k+1.
- Any cycle without a beat (bubble, flush, idle) drives c_out=0, x_out=0, s_out=0. The array is never stalled, and bubbles are legal mid-frame.
- s_out=1 only with the first beat of a frame, i.e. a beat taken in IDLE. All later beats of the frame have s_out=0.
- FSM:
  - IDLE: on beat -> s_out=1, beat counter=1. If x_in_last=1 -> FLUSH, otherwise -> STREAM. With no beat, stay in IDLE.
  - STREAM: on beat -> s_out=0, beat counter +1 (saturates at all-ones). If x_in_last=1 -> FLUSH. With no beat, emit a bubble and stay in STREAM.
  - FLUSH: entered on the last-beat edge with flush counter=FLUSH_CYCLES. Each edge emits zeros and decrements the counter. On the edge where the counter equals 1: state<=IDLE, frame_done<=1 for one cycle, frame_beats<=beat counter, beat counter<=0.
- Single-beat frame: the same beat has s_out=1 and enters FLUSH directly, giving frame_beats=1.
- After the last beat, exactly FLUSH_CYCLES zero-output cycles follow. frame_done is high in the first IDLE cycle, and a new beat may be accepted in that same cycle.
- x_in_last is ignored unless a beat occurs.
- busy = (state != IDLE), combinational from state.
- Reset asserted mid-frame or mid-flush: immediate return to reset values. No frame_done, and the partial frame is discarded.

Test Plan:
- Reset: hold rst=0 with all valids high -> both readys low, all outputs 0; after release the first beat shows s_out=1.
- 3-beat frame, c={2,3,4}, x={10,11,12}, last on 3rd, both valids continuous -> s_out 1,0,0 with matching pairs on cycles k+1..k+3; then 4 zero cycles (N_CELLS=4) with readys low; frame_done pulse; frame_beats=3.
- Join stall: c_in_valid high, x_in_valid low for 5 cycles, then x valid -> c_in_ready=0 and zero bubbles for those 5 cycles; exactly one beat on the 6th edge with the correct pair.
- Mid-frame bubble: frame {c=1,x=5},gap,{c=7,x=9,last} -> outputs show pair, zeros with s=0, pair; frame_beats=2.
- Back-to-back frames: second frame valid during flush -> readys low for all 4 flush cycles; second frame's first beat is accepted in the frame_done cycle with s_out=1.
- Reset mid-flush after 2 of 4 zero cycles -> outputs 0, state IDLE, no frame_done pulse, frame_beats=0.
